// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: word width, link register,
// write-back source encodings and the source-priority helper.
package mem_wb_stage_pkg;

    localparam int unsigned       WORD_W        = 32;
    localparam logic [4:0]        LINK_REG_DFLT = 5'd31;
    localparam logic [WORD_W-1:0] WORD_ZERO     = '0;

    typedef enum logic [1:0] {
        WB_SEL_ALU,
        WB_SEL_MEM,
        WB_SEL_LUI,
        WB_SEL_LINK
    } wb_sel_e;

    // jal beats lui beats load beats ALU
    function automatic wb_sel_e wb_select(input logic jal, input logic lui, input logic mem);
        if (jal)      return WB_SEL_LINK;
        else if (lui) return WB_SEL_LUI;
        else if (mem) return WB_SEL_MEM;
        else          return WB_SEL_ALU;
    endfunction

endpackage

// File: rtl/mem_wb_stage_data_ram.sv
// Single-port data RAM: synchronous write, asynchronous read, no reset.
module data_ram
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned DADDR_W = 10
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [DADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0]  i_wdata,
    output logic [WORD_W-1:0]  o_rdata
);

    logic [WORD_W-1:0] r_mem [2**DADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register: data RAM access, lb
// extraction, write-back select, forwarding tap, sticky halt, retire count.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned DADDR_W  = 10,
    parameter logic [4:0]  LINK_REG = LINK_REG_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_i,
    input  logic [4:0]  rw_i,
    input  logic        jal_i,
    input  logic        Memwrite_i,
    input  logic        MemToReg_i,
    input  logic        Regwrite_i,
    input  logic        lb_i,
    input  logic        lui_i,
    input  logic [31:0] B_i,
    input  logic [31:0] Imm_i,
    input  logic [31:0] PC_i,
    input  logic [31:0] ALU_i,
    output logic [31:0] fwd_data_o,
    output logic [4:0]  fwd_rw_o,
    output logic        fwd_we_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_rw_o,
    output logic        wb_we_o,
    output logic        halt_o,
    output logic [31:0] retired_o
);

    logic [DADDR_W-1:0] w_idx;
    logic               w_ram_we;
    logic [WORD_W-1:0]  w_rdata;
    logic [7:0]         w_byte;
    logic [WORD_W-1:0]  w_load;
    logic [WORD_W-1:0]  w_wb_data;
    logic [4:0]         w_rw_dest;
    wb_sel_e            w_sel;
    logic               w_unused_bits;

    logic [WORD_W-1:0]  r_wb_data;
    logic [4:0]         r_wb_rw;
    logic               r_wb_we;
    logic               r_halt;
    logic [WORD_W-1:0]  r_retired;

    assign w_idx         = ALU_i[DADDR_W+1:2];
    assign w_unused_bits = ^{ALU_i[WORD_W-1:DADDR_W+2], Imm_i[31:16]};
    // rst and halt both block the store, keeping RAM untouched across reset
    assign w_ram_we      = Memwrite_i & ~r_halt & ~rst;

    data_ram #(
        .DADDR_W (DADDR_W)
    ) u_data_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_idx),
        .i_wdata (B_i),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_byte = w_rdata[7:0];
        case (ALU_i[1:0])
            2'd0: w_byte = w_rdata[7:0];
            2'd1: w_byte = w_rdata[15:8];
            2'd2: w_byte = w_rdata[23:16];
            2'd3: w_byte = w_rdata[31:24];
            default: w_byte = w_rdata[7:0];
        endcase
    end

    assign w_load = lb_i ? {{24{w_byte[7]}}, w_byte} : w_rdata;
    assign w_sel  = wb_select(jal_i, lui_i, MemToReg_i);

    always_comb begin
        w_wb_data = ALU_i;
        case (w_sel)
            WB_SEL_LINK: w_wb_data = PC_i + 32'd1;
            WB_SEL_LUI:  w_wb_data = {Imm_i[15:0], 16'h0000};
            WB_SEL_MEM:  w_wb_data = w_load;
            WB_SEL_ALU:  w_wb_data = ALU_i;
            default:     w_wb_data = ALU_i;
        endcase
    end

    assign w_rw_dest  = jal_i ? LINK_REG : rw_i;

    assign fwd_data_o = w_wb_data;
    assign fwd_rw_o   = w_rw_dest;
    assign fwd_we_o   = Regwrite_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_data <= WORD_ZERO;
            r_wb_rw   <= '0;
            r_wb_we   <= 1'b0;
            r_halt    <= 1'b0;
            r_retired <= WORD_ZERO;
        end else begin
            r_wb_data <= w_wb_data;
            r_wb_rw   <= w_rw_dest;
            r_wb_we   <= Regwrite_i & (w_rw_dest != 5'd0) & ~r_halt;
            r_halt    <= r_halt | halt_i;
            if ((Regwrite_i | Memwrite_i) & ~r_halt) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign wb_data_o = r_wb_data;
    assign wb_rw_o   = r_wb_rw;
    assign wb_we_o   = r_wb_we;
    assign halt_o    = r_halt;
    assign retired_o = r_retired;

endmodule
